// File: rtl/systolic_feeder.sv
// Transmit-side feeder for the systolic array: loads weight rows onto b, pulses switch,
// then skews activation vectors onto a and flushes. Optional FEEDER_PERF_CNT_EN adds perf_cycles.
module systolic_feeder #(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_is_wt,
  input  logic            in_last,
  input  logic [N*DW-1:0] in_data,
  output logic [N*DW-1:0] a_out,
  output logic [N*DW-1:0] b_out,
  output logic            switch_out,
  output logic            busy,
  output logic            done,
  output logic            err
`ifdef FEEDER_PERF_CNT_EN
  ,
  output logic [31:0]     perf_cycles
`endif
);

  localparam int WCW = $clog2(N + 1);
  localparam int DCW = $clog2(2 * N);

  typedef enum logic [2:0] {IDLE, LOAD_W, FLIP, STREAM, DRAIN} state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] wcnt;
  logic [DCW-1:0] dcnt;
  logic           xfer, wt_xfer, act_xfer;
  logic           drain_last;
  logic           shift;

  assign xfer       = in_valid && in_ready;
  assign wt_xfer    = xfer && in_is_wt;
  assign act_xfer   = xfer && !in_is_wt;
  assign drain_last = (dcnt == DCW'(2 * N - 2));
  assign shift      = (state == STREAM) || (state == DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wt_xfer) state_nxt = (N == 1) ? FLIP : LOAD_W;
      LOAD_W:  if (wt_xfer && (wcnt == WCW'(N - 1))) state_nxt = FLIP;
      FLIP:    state_nxt = STREAM;
      STREAM:  if (act_xfer && in_last) state_nxt = DRAIN;
      DRAIN:   if (drain_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready is gated by rst so it reads 0 while reset is held and 1 as soon as it drops
  always_comb begin
    in_ready   = !rst && ((state == IDLE) || (state == LOAD_W) || (state == STREAM));
    switch_out = (state == FLIP);
    busy       = (state != IDLE);
    done       = (state == DRAIN) && drain_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt  <= '0;
      b_out <= '0;
    end else begin
      case (state)
        IDLE: if (wt_xfer) begin
          b_out <= in_data;
          wcnt  <= WCW'(1);
        end
        LOAD_W: if (wt_xfer) begin
          b_out <= in_data;
          wcnt  <= wcnt + WCW'(1);
        end
        FLIP: begin
          b_out <= '0;
          wcnt  <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  dcnt <= '0;
    else if (state == DRAIN)  dcnt <= dcnt + DCW'(1);
    else                      dcnt <= '0;
  end

  // Wrong-type beats are dropped; the flag stays set until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if ((act_xfer && ((state == IDLE) || (state == LOAD_W))) ||
             (wt_xfer && (state == STREAM)))
      err <= 1'b1;
  end

  // Skew line: row i is an (i+1)-deep shift register; its tail drives a_out[i]
  for (genvar i = 0; i < N; i++) begin : g_row
    logic [DW-1:0] stage_p [i+1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= i; k++) stage_p[k] <= '0;
      end else if (shift) begin
        stage_p[0] <= act_xfer ? in_data[i*DW +: DW] : '0;
        for (int k = 1; k <= i; k++) stage_p[k] <= stage_p[k-1];
      end else begin
        for (int k = 0; k <= i; k++) stage_p[k] <= '0;
      end
    end

    assign a_out[i*DW +: DW] = stage_p[i];
  end

`ifdef FEEDER_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // The accepting cycle of the first weight row already belongs to the tile, so restart at 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           perf_cycles <= '0;
    else if ((state == IDLE) && wt_xfer) perf_cycles <= 32'd1;
    else if (busy)                     perf_cycles <= sat_inc(perf_cycles);
  end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder with a tile-level reference model and directed literal checks.
// Define FEEDER_PERF_CNT_EN for both files to cover the perf counter.
module tb_systolic_feeder;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int W  = N * DW;

  localparam int M_IDLE = 0, M_LOAD = 1, M_FLIP = 2, M_STREAM = 3, M_DRAIN = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_is_wt = 1'b0;
  logic         in_last = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] a_out, b_out;
  logic         switch_out, busy, done, err;
`ifdef FEEDER_PERF_CNT_EN
  logic [31:0]  perf_cycles;
`endif

  systolic_feeder #(.N(N), .DW(DW)) dut (
`ifdef FEEDER_PERF_CNT_EN
    .perf_cycles(perf_cycles),
`endif
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_wt(in_is_wt), .in_last(in_last), .in_data(in_data),
    .a_out(a_out), .b_out(b_out), .switch_out(switch_out),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: tile phase, counters, and a history of the last N activation inputs
  int           m_mode;
  int           m_wrows;
  int           m_drain_left;
  logic         m_err;
  logic [W-1:0] m_b;
  logic [W-1:0] m_hist[$];
  logic [31:0]  m_perf;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] a_el(input int i);
    return a_out[i*DW +: DW];
  endfunction

  function automatic logic [W-1:0] splat(input logic [DW-1:0] v);
    logic [W-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] vec4(input logic [DW-1:0] e0, e1, e2, e3);
    logic [W-1:0] r;
    r = {e3, e2, e1, e0};
    return r;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_wrows = 0;
    m_drain_left = 0;
    m_err = 1'b0;
    m_b = '0;
    m_perf = '0;
    m_hist.delete();
    for (int k = 0; k < N; k++) m_hist.push_back('0);
  endtask

  function automatic logic m_ready();
    return (m_mode == M_IDLE) || (m_mode == M_LOAD) || (m_mode == M_STREAM);
  endfunction

  task automatic compare_all();
    logic [W-1:0] exp_a;
    for (int i = 0; i < N; i++) exp_a[i*DW +: DW] = m_hist[i][i*DW +: DW];
    chk("in_ready", in_ready, m_ready());
    chk("busy", busy, m_mode != M_IDLE);
    chk("switch_out", switch_out, m_mode == M_FLIP);
    chk("done", done, (m_mode == M_DRAIN) && (m_drain_left == 1));
    chk("err", err, m_err);
    chk("b_out", b_out, m_b);
    chk("a_out", a_out, exp_a);
`ifdef FEEDER_PERF_CNT_EN
    chk("perf_cycles", perf_cycles, m_perf);
`endif
  endtask

  task automatic model_advance(input logic v, input logic wt, input logic last, input logic [W-1:0] d);
    logic         x;
    logic [W-1:0] pushed;
    logic         was_busy;
    logic         tile_start;
    x = v && m_ready();
    pushed = '0;
    was_busy = (m_mode != M_IDLE);
    tile_start = 1'b0;
    case (m_mode)
      M_IDLE: if (x && wt) begin
        m_b = d; m_wrows = 1; tile_start = 1'b1;
        m_mode = (m_wrows == N) ? M_FLIP : M_LOAD;
      end else if (x) m_err = 1'b1;
      M_LOAD: if (x && wt) begin
        m_b = d; m_wrows++;
        if (m_wrows == N) m_mode = M_FLIP;
      end else if (x) m_err = 1'b1;
      M_FLIP: begin
        m_b = '0; m_mode = M_STREAM;
      end
      M_STREAM: if (x && !wt) begin
        pushed = d;
        if (last) begin m_mode = M_DRAIN; m_drain_left = 2 * N - 1; end
      end else if (x) m_err = 1'b1;
      default: begin
        m_drain_left--;
        if (m_drain_left == 0) m_mode = M_IDLE;
      end
    endcase
    if (tile_start) m_perf = 32'd1;
    else if (was_busy && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
    m_hist.push_front(pushed);
    void'(m_hist.pop_back());
  endtask

  // Called at a falling edge: check this cycle, drive the beat, advance to the next falling edge
  task automatic step(input logic v, input logic wt, input logic last, input logic [W-1:0] d);
    compare_all();
    in_valid = v; in_is_wt = wt; in_last = last; in_data = d;
    model_advance(v, wt, last, d);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic load_weights();
    for (int r = N; r >= 1; r--) step(1'b1, 1'b1, 1'b0, splat(DW'(r)));
  endtask

  task automatic async_reset();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst in_ready", in_ready, 1'b0);
    chk("rst a_out", a_out, '0);
    chk("rst b_out", b_out, '0);
    chk("rst switch_out", switch_out, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready after rst", in_ready, 1'b1);
    model_reset();
  endtask

  initial begin
    logic [W-1:0] v0, v1, d;
    logic         v, wt, last;
    model_reset();
    #1;
    chk("init in_ready", in_ready, 1'b0);
    chk("init busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("init in_ready after rst", in_ready, 1'b1);

    // Weights 4,3,2,1 back-to-back
    for (int r = N; r >= 1; r--) begin
      step(1'b1, 1'b1, 1'b0, splat(DW'(r)));
      chk("b_out row", b_out, splat(DW'(r)));
    end
    chk("switch pulse", switch_out, 1'b1);
    chk("flip in_ready", in_ready, 1'b0);
    idle(1);
    chk("switch one cycle", switch_out, 1'b0);
    chk("b_out cleared", b_out, '0);

    // Single-vector tile, skew timing and drain length
    step(1'b1, 1'b0, 1'b1, vec4(10, 20, 30, 40));
    chk("skew a0", a_el(0), 10);
    idle(1); chk("skew a1", a_el(1), 20);
    idle(1); chk("skew a2", a_el(2), 30);
    idle(1); chk("skew a3", a_el(3), 40);
    idle(2); chk("drain no done", done, 1'b0);
    idle(1); chk("drain done", done, 1'b1);
    idle(1); chk("back to idle", busy, 1'b0);
`ifdef FEEDER_PERF_CNT_EN
    chk("perf tile", perf_cycles, 32'd13);
`endif

    // Activation beat in IDLE is an error
    step(1'b1, 1'b0, 1'b0, vec4(1, 2, 3, 4));
    chk("err set", err, 1'b1);
    chk("err stays idle", busy, 1'b0);

    // Bubble between two vectors
    v0 = vec4(32'h11, 32'h12, 32'h13, 32'h14);
    v1 = vec4(32'h21, 32'h22, 32'h23, 32'h24);
    load_weights();
    idle(1);
    step(1'b1, 1'b0, 1'b0, v0); chk("bubble v0", a_el(0), 32'h11);
    step(1'b0, 1'b0, 1'b0, '0); chk("bubble gap", a_el(0), 0);
    step(1'b1, 1'b0, 1'b1, v1); chk("bubble v1", a_el(0), 32'h21);
    chk("bubble a1 of v0", a_el(1), 32'h0);
    idle(2 * N - 1);
    chk("err sticky", err, 1'b1);
    chk("idle after tile", busy, 1'b0);

    // Reset mid-STREAM with data in flight
    load_weights();
    idle(1);
    step(1'b1, 1'b0, 1'b0, vec4(5, 6, 7, 8));
    step(1'b1, 1'b0, 1'b0, vec4(9, 10, 11, 12));
    async_reset();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) async_reset();
      v = ($urandom_range(0, 3) != 0);
      if (m_mode == M_IDLE || m_mode == M_LOAD) wt = ($urandom_range(0, 19) != 0);
      else if (m_mode == M_STREAM) wt = ($urandom_range(0, 19) == 0);
      else wt = 1'($urandom_range(0, 1));
      last = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < N; k++) d[k*DW +: DW] = $urandom;
      step(v, wt, last, d);
    end
    compare_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
